yuv422_word_packer: RTL and testbench
=====================================

// Module: yuv422_word_packer
// PURPOSE
//   Downstream stage of the CTE colour-transform engine. Consumes its serial 4:2:2 byte stream
//   (out_valid/yuv_out, order U,Y0,V,Y1 repeating) and assembles each group into one 32-bit UYVY word.
//   Buffers words in a small FIFO and presents them on a valid/ready interface to the frame-store writer.
// PARAMETERS
//   DEPTH  4  FIFO depth in 32-bit words; power of two, >=2
//   AW     2  log2(DEPTH); pointer width
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low reset
//   in_valid   in   1     byte strobe (driven by CTE out_valid)
//   in_data    in   8     byte (driven by CTE yuv_out); U/V two's-complement, Y unsigned, passed unmodified
//   sync_clr   in   1     synchronous realign: next accepted byte is U
//   out_valid  out  1     FIFO non-empty
//   out_data   out  32    {U,Y0,V,Y1}; U in [31:24], Y1 in [7:0]
//   out_ready  in   1     consumer accepts word when out_valid&&out_ready
//   full       out  1     level==DEPTH
//   overflow   out  1     sticky: a completed word was dropped
//   level      out  AW+1  words held, 0..DEPTH
// BEHAVIOUR
//   - Reset (reset==0, async): phase=0, byte regs=0, pointers=0, level=0, out_valid=0, out_data=0,
//     full=0, overflow=0. Reset mid-word discards partial bytes. FIFO contents are lost.
//   - Phase counter 2 bits, 0=U 1=Y0 2=V 3=Y1. Advances only on in_valid. Wraps 3->0.
//     Gaps of any length between bytes are allowed.
//   - Phase 0..2 with in_valid: store byte in lane [31:24]/[23:16]/[15:8].
//   - Phase 3 with in_valid: form word {U,Y0,V,in_data} and push.
//     The push is accepted if level<DEPTH, or if a pop occurs in the same cycle.
//     Otherwise drop the word, set overflow, and wrap the phase anyway.
//   - Pop: out_valid&&out_ready. rd_ptr++ mod DEPTH.
//   - Level: push only +1; pop only -1; push and pop together: unchanged.
//   - Latency: word written on 4th-byte edge; out_valid/out_data reflect it the next cycle
//     (1 cycle, FIFO empty case).
//   - out_data = mem[rd_ptr] from registered storage. Stable while out_valid&&!out_ready.
//     Value is don't-care when empty, but must never be X after reset.
//   - Order: strict FIFO; words leave in completion order.
//   - sync_clr: phase<=0 and partial bytes discarded. FIFO, level and pointers untouched. Clears overflow.
//     With in_valid in the same cycle, that byte is taken as U (phase becomes 1).
//     Priority over overflow set is irrelevant: a phase-3 completion cannot coincide with sync_clr,
//     because sync_clr wins and the byte is treated as U.
//   - No backpressure to CTE, which cannot stall its output. Upstream control uses full to gate CTE in_en.
// CONFIGURATION
//   YUV_PACK_STATS_EN defined:
//     adds out port pair_cnt[15:0], counting accepted words (wraps FFFF->0000);
//     adds out port drop_cnt[7:0], counting dropped words (saturates at FF).
//     Both reset to 0 on reset; sync_clr does not clear them.
//   YUV_PACK_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.
// TESTING
//   1 Assert reset low mid-stream -> all outputs 0 immediately (async), level=0.
//     After release, the next byte is U.
//   2 Bytes 80,10,7F,20 on 4 consecutive cycles, out_ready=0 -> one cycle after the 4th:
//     out_valid=1, out_data=80107F20, level=1.
//   3 Same bytes with 0-3 idle cycles between them -> identical word, no extra words.
//   4 out_ready=0, 5 words (01020304..11121314) -> level=4, full=1, overflow=1, 5th dropped.
//     Then out_ready=1 -> 01020304,05060708,090A0B0C,0D0E0F10 out in order, then out_valid=0.
//   5 full, out_ready=1 during a 4th byte -> pop and push same edge: level stays 4, overflow stays 0.
//   6 Bytes AA,BB, then sync_clr, then 11,22,33,44 -> single word 11223344; overflow cleared.
//     STATS build: pair_cnt increments by 1 per word.

Source files
------------

// File: rtl/yuv422_word_packer.sv
// yuv422_word_packer
//   Packs the serial 4:2:2 byte stream (U, Y0, V, Y1 repeating) into 32-bit
//   UYVY words {U,Y0,V,Y1} and buffers them in a DEPTH-word FIFO that drains
//   over a valid/ready interface. The upstream source cannot stall. When the
//   FIFO has no room, a completed word is dropped and the sticky overflow flag
//   is set.
//   Optional build macro YUV_PACK_STATS_EN adds two ports:
//     pair_cnt (accepted words, wraps)
//     drop_cnt (dropped words, saturates)
module yuv422_word_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          sync_clr,
  output logic          out_valid,
  output logic [31:0]   out_data,
  input  logic          out_ready,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   level
`ifdef YUV_PACK_STATS_EN
  ,
  output logic [15:0]   pair_cnt,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Byte-assembly state. U and V carry signed chroma; they are stored and
  // forwarded bit-exact.
  logic [1:0]         phase_q, phase_d;
  logic signed [7:0]  u_q, u_d;
  logic [7:0]         y0_q, y0_d;
  logic signed [7:0]  v_q, v_d;

  // FIFO state
  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               overflow_q, overflow_d;

  logic               pop;
  logic               push_req;
  logic               push_ok;
  logic               drop;
  logic [31:0]        word_in;

  // Handshake decode: a sync_clr byte is always treated as U, so a completion
  // can never coincide with a realign.
  always_comb begin
    pop      = (level_q != '0) && out_ready;
    push_req = in_valid && !sync_clr && (phase_q == 2'd3);
    push_ok  = push_req && ((level_q < LVL_MAX) || pop);
    drop     = push_req && !push_ok;
    word_in  = {u_q, y0_q, v_q, in_data};
  end

  // Next-state for phase, byte lanes, pointers, level and the sticky flag.
  always_comb begin
    phase_d    = phase_q;
    u_d        = u_q;
    y0_d       = y0_q;
    v_d        = v_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;

    if (sync_clr) begin
      // Realign: discard partial bytes; a coincident byte becomes the new U.
      phase_d    = in_valid ? 2'd1 : 2'd0;
      u_d        = in_valid ? in_data : 8'sd0;
      y0_d       = 8'd0;
      v_d        = 8'sd0;
      overflow_d = 1'b0;
    end else if (in_valid) begin
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd0:    u_d  = in_data;
        2'd1:    y0_d = in_data;
        2'd2:    v_d  = in_data;
        default: ;
      endcase
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and byte-lane registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= 2'd0;
      u_q        <= 8'sd0;
      y0_q       <= 8'd0;
      v_q        <= 8'sd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      u_q        <= u_d;
      y0_q       <= y0_d;
      v_q        <= v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage. It is cleared on reset so out_data is never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

`ifdef YUV_PACK_STATS_EN
  logic [15:0] pair_cnt_q;
  logic [7:0]  drop_cnt_q;

  // Word statistics: these survive sync_clr and clear only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_cnt_q <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (push_ok) pair_cnt_q <= pair_cnt_q + 16'd1;
      if (drop)    drop_cnt_q <= sat_inc8(drop_cnt_q);
    end
  end

  assign pair_cnt = pair_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign full      = (level_q == LVL_MAX);
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_yuv422_word_packer.sv
// Bench for yuv422_word_packer. Expected words are queued as stimulus is
// driven. A monitor pops and compares a word on every pop handshake.
module tb_yuv422_word_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        sync_clr;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        full;
  logic        overflow;
  logic [2:0]  level;
`ifdef YUV_PACK_STATS_EN
  logic [15:0] pair_cnt;
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  yuv422_word_packer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .sync_clr(sync_clr), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .full(full), .overflow(overflow), .level(level)
`ifdef YUV_PACK_STATS_EN
    , .pair_cnt(pair_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a pop happens on the next rising edge whenever valid&&ready.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected out_data=%h expected none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_word out_data=%h expected %h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit accept);
    if (accept) exp_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_sync();
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 20) begin
      tick(); n++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || n >= 20) begin
      errors++;
      $display("FAIL drain_timeout out_valid=%b cycles=%0d expected 0", out_valid, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_missing words_left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    // Reset held from time 0: all outputs must be zero.
    checks++;
    if ({out_valid, out_data, full, overflow, level} !== 38'd0) begin
      errors++;
      $display("FAIL reset_initial ov=%b od=%h f=%b of=%b lv=%0d expected zeros",
               out_valid, out_data, full, overflow, level);
    end
    tick(); reset = 1'b1; tick();
    // One complete word followed by a partial one, then an async reset mid-cycle.
    send_word(32'hA1A2A3A4, 1'b1);
    send_byte(8'h55); send_byte(8'h66);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({out_valid, out_data, full, overflow, level} !== 38'd0) begin
      errors++;
      $display("FAIL reset_async ov=%b od=%h f=%b of=%b lv=%0d expected zeros",
               out_valid, out_data, full, overflow, level);
    end
    tick(); reset = 1'b1; tick();
    // The first byte after reset must be taken as U.
    send_word(32'h12345678, 1'b1);
    checks++;
    if (level !== 3'd1 || out_data !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_realign level=%0d out_data=%h expected 1 12345678", level, out_data);
    end
    drain();
  endtask

  task automatic test_basic();
    exp_q.push_back(32'h80107F20);
    send_byte(8'h80); send_byte(8'h10); send_byte(8'h7F);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early out_valid=%b expected 0", out_valid);
    end
    send_byte(8'h20);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h80107F20 || level !== 3'd1) begin
      errors++;
      $display("FAIL basic_word ov=%b od=%h lv=%0d expected 1 80107f20 1",
               out_valid, out_data, level);
    end
    drain();
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      w = 32'h80107F20;
      exp_q.push_back(w);
      for (int i = 3; i >= 0; i--) begin
        send_byte(w[i*8 +: 8]);
        repeat ($urandom_range(0, 3)) tick();
      end
      checks++;
      if (level !== 3'd1) begin
        errors++;
        $display("FAIL gaps_level iter=%0d level=%0d expected 1", k, level);
      end
      drain();
    end
  endtask

  task automatic test_overflow();
`ifdef YUV_PACK_STATS_EN
    logic [7:0] d0;
    d0 = drop_cnt;
`endif
    send_word(32'h01020304, 1'b1);
    send_word(32'h05060708, 1'b1);
    send_word(32'h090A0B0C, 1'b1);
    send_word(32'h0D0E0F10, 1'b1);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full full=%b overflow=%b expected 1 0", full, overflow);
    end
    send_word(32'h11121314, 1'b0);
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop level=%0d full=%b overflow=%b expected 4 1 1",
               level, full, overflow);
    end
`ifdef YUV_PACK_STATS_EN
    checks++;
    if (drop_cnt !== d0 + 8'd1) begin
      errors++;
      $display("FAIL ovf_dropcnt drop_cnt=%0d expected %0d", drop_cnt, d0 + 8'd1);
    end
`endif
    drain();
    checks++;
    if (level !== 3'd0 || full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after level=%0d full=%b overflow=%b expected 0 0 1",
               level, full, overflow);
    end
  endtask

  task automatic test_back_to_back();
    pulse_sync();
    send_word(32'hA0A1A2A3, 1'b1);
    send_word(32'hB0B1B2B3, 1'b1);
    send_word(32'hC0C1C2C3, 1'b1);
    send_word(32'hD0D1D2D3, 1'b1);
    send_byte(8'hE0); send_byte(8'hE1); send_byte(8'hE2);
    // The pop of the head word and the push of the new word share one edge.
    exp_q.push_back(32'hE0E1E2E3);
    in_valid = 1'b1; in_data = 8'hE3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_level level=%0d full=%b overflow=%b expected 4 1 0",
               level, full, overflow);
    end
    drain();
  endtask

  task automatic test_sync_clr();
`ifdef YUV_PACK_STATS_EN
    logic [15:0] p0;
`endif
    // Make overflow set, then empty the FIFO so only sync_clr can clear it.
    send_word(32'h21222324, 1'b1);
    send_word(32'h25262728, 1'b1);
    send_word(32'h292A2B2C, 1'b1);
    send_word(32'h2D2E2F30, 1'b1);
    send_word(32'h31323334, 1'b0);
    drain();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL sync_pre overflow=%b expected 1", overflow);
    end
`ifdef YUV_PACK_STATS_EN
    p0 = pair_cnt;
`endif
    send_byte(8'hAA); send_byte(8'hBB);
    pulse_sync();
    checks++;
    if (overflow !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL sync_clear overflow=%b level=%0d expected 0 0", overflow, level);
    end
    send_word(32'h11223344, 1'b1);
    checks++;
    if (level !== 3'd1 || out_data !== 32'h11223344) begin
      errors++;
      $display("FAIL sync_word level=%0d out_data=%h expected 1 11223344", level, out_data);
    end
`ifdef YUV_PACK_STATS_EN
    checks++;
    if (pair_cnt !== p0 + 16'd1) begin
      errors++;
      $display("FAIL sync_paircnt pair_cnt=%0d expected %0d", pair_cnt, p0 + 16'd1);
    end
`endif
    drain();
    // A byte coincident with sync_clr is taken as the new U.
    send_byte(8'hAA);
    exp_q.push_back(32'h55667788);
    sync_clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    sync_clr = 1'b0;
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    checks++;
    if (level !== 3'd1 || out_data !== 32'h55667788) begin
      errors++;
      $display("FAIL sync_same_cycle level=%0d out_data=%h expected 1 55667788",
               level, out_data);
    end
    drain();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    sync_clr = 1'b0; out_ready = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_sync_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
